// File: rtl/lrsc_reservation_ctrl.sv
// rtl/lrsc_reservation_ctrl.sv - per-hart LR/SC reservation manager
//
// Holds one address reservation per hart for the barrel-threaded RV32 core.
// It decides whether a store-conditional succeeds and returns the SC result
// one cycle later. Reservations age out after TIMEOUT cycles.
//
// Ports:
//   clk          core clock
//   reset        asynchronous active-high reset
//   i_valid      instruction in this stage is valid
//   i_hart_id    hart owning the current instruction
//   i_lr         load-reserved
//   i_sc         store-conditional
//   i_store      ordinary store
//   i_addr       effective address
//   o_sc_mem_we  combinational; SC store permitted this cycle
//   o_sc_done    registered; SC result valid (one cycle after SC)
//   o_sc_fail    registered; SC rd bit 0 (1 = fail)
//   o_res_valid  registered per-hart reservation valid
module lrsc_reservation_ctrl #(
    parameter int NUM_HARTS   = 16,
    parameter int HART_ID_W   = 4,
    parameter int ADDR_W      = 32,
    parameter int GRANULE_LSB = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [HART_ID_W-1:0] i_hart_id,
    input  logic                 i_lr,
    input  logic                 i_sc,
    input  logic                 i_store,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 o_sc_mem_we,
    output logic                 o_sc_done,
    output logic                 o_sc_fail,
    output logic [NUM_HARTS-1:0] o_res_valid
);

    localparam int TAG_W = ADDR_W - GRANULE_LSB;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [NUM_HARTS-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag   [NUM_HARTS];
    logic [TMR_W-1:0]     r_timer [NUM_HARTS];
    logic                 r_sc_done;
    logic                 r_sc_fail;

    logic             w_accept;
    logic             w_op_sc;
    logic             w_op_lr;
    logic             w_op_st;
    logic [TAG_W-1:0] w_tag;
    logic             w_sc_success;
    logic             w_inval_en;

    assign w_accept = i_valid && (32'(i_hart_id) < NUM_HARTS);
    assign w_tag    = i_addr[ADDR_W-1:GRANULE_LSB];

    // Priority SC > LR > store when the decoder raises more than one
    assign w_op_sc = w_accept && i_sc;
    assign w_op_lr = w_accept && i_lr && !i_sc;
    assign w_op_st = w_accept && i_store && !i_sc && !i_lr;

    // Checked against registered state, before this cycle's updates
    always_comb begin
        w_sc_success = 1'b0;
        if (w_op_sc) begin
            w_sc_success = r_valid[i_hart_id] && (r_tag[i_hart_id] == w_tag);
        end
    end

    // Only stores that actually write memory kill other harts' reservations
    assign w_inval_en = w_op_st || w_sc_success;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_sc_done <= 1'b0;
            r_sc_fail <= 1'b0;
            for (int g = 0; g < NUM_HARTS; g++) begin
                r_tag[g]   <= '0;
                r_timer[g] <= '0;
            end
        end else begin
            r_sc_done <= w_op_sc;
            r_sc_fail <= w_op_sc && !w_sc_success;
            for (int g = 0; g < NUM_HARTS; g++) begin
                // Ageing; later assignments in this loop body override it
                if (TIMEOUT > 0 && r_valid[g]) begin
                    r_timer[g] <= r_timer[g] - 1'b1;
                    if (r_timer[g] == TMR_W'(1)) begin
                        r_valid[g] <= 1'b0;
                    end
                end
                if (w_inval_en && (HART_ID_W'(g) != i_hart_id) && (r_tag[g] == w_tag)) begin
                    r_valid[g] <= 1'b0;
                end
                if (w_op_sc && (HART_ID_W'(g) == i_hart_id)) begin
                    r_valid[g] <= 1'b0;
                end
                // LR reload wins over a same-cycle expiry
                if (w_op_lr && (HART_ID_W'(g) == i_hart_id)) begin
                    r_valid[g] <= 1'b1;
                    r_tag[g]   <= w_tag;
                    r_timer[g] <= TMR_W'(TIMEOUT);
                end
            end
        end
    end

    assign o_sc_mem_we = w_sc_success;
    assign o_sc_done   = r_sc_done;
    assign o_sc_fail   = r_sc_fail;
    assign o_res_valid = r_valid;

endmodule

// File: tb/tb_lrsc_reservation_ctrl.sv
// tb/tb_lrsc_reservation_ctrl.sv - directed self-checking bench for lrsc_reservation_ctrl
module tb_lrsc_reservation_ctrl;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [3:0]  i_hart_id;
    logic        i_lr;
    logic        i_sc;
    logic        i_store;
    logic [31:0] i_addr;

    logic        o_sc_mem_we,  o_sc_done,  o_sc_fail;
    logic [15:0] o_res_valid;
    logic        o_sc_mem_we8, o_sc_done8, o_sc_fail8;
    logic [15:0] o_res_valid8;

    int n_tests;
    int n_fail;

    lrsc_reservation_ctrl #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_hart_id(i_hart_id),
        .i_lr(i_lr), .i_sc(i_sc), .i_store(i_store), .i_addr(i_addr),
        .o_sc_mem_we(o_sc_mem_we), .o_sc_done(o_sc_done), .o_sc_fail(o_sc_fail),
        .o_res_valid(o_res_valid)
    );

    lrsc_reservation_ctrl #(.TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_hart_id(i_hart_id),
        .i_lr(i_lr), .i_sc(i_sc), .i_store(i_store), .i_addr(i_addr),
        .o_sc_mem_we(o_sc_mem_we8), .o_sc_done(o_sc_done8), .o_sc_fail(o_sc_fail8),
        .o_res_valid(o_res_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; #1 lets combinational outputs settle
    task automatic drive(input logic v, input int h, input logic lr, input logic sc,
                         input logic st, input logic [31:0] a);
        i_valid   = v;
        i_hart_id = 4'(h);
        i_lr      = lr;
        i_sc      = sc;
        i_store   = st;
        i_addr    = a;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (n) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_res_valid", 32'(o_res_valid), 32'h0);
        check("reset_sc_done",   32'(o_sc_done),   32'h0);
        check("reset_sc_fail",   32'(o_sc_fail),   32'h0);

        // LR/SC pair succeeds, a repeated SC fails
        drive(1'b1, 3, 1'b1, 1'b0, 1'b0, 32'h100); step();
        check("lr3_res_valid", 32'(o_res_valid), 32'h0008);
        drive(1'b1, 3, 1'b0, 1'b1, 1'b0, 32'h100);
        check("sc3_mem_we", 32'(o_sc_mem_we), 32'h1);
        step();
        check("sc3_done", 32'(o_sc_done), 32'h1);
        check("sc3_fail", 32'(o_sc_fail), 32'h0);
        check("sc3_cleared", 32'(o_res_valid), 32'h0);
        drive(1'b1, 3, 1'b0, 1'b1, 1'b0, 32'h100);
        check("sc3b_mem_we", 32'(o_sc_mem_we), 32'h0);
        step();
        check("sc3b_done", 32'(o_sc_done), 32'h1);
        check("sc3b_fail", 32'(o_sc_fail), 32'h1);
        idle(1);
        check("done_one_cycle", 32'(o_sc_done), 32'h0);
        check("fail_one_cycle", 32'(o_sc_fail), 32'h0);

        // Store by another hart to the same word kills the reservation
        drive(1'b1, 1, 1'b1, 1'b0, 1'b0, 32'h200); step();
        drive(1'b1, 2, 1'b0, 1'b0, 1'b1, 32'h202); step();
        check("st2_kills_h1", 32'(o_res_valid[1]), 32'h0);
        drive(1'b1, 1, 1'b0, 1'b1, 1'b0, 32'h200);
        check("sc1_mem_we", 32'(o_sc_mem_we), 32'h0);
        step();
        check("sc1_fail", 32'(o_sc_fail), 32'h1);

        // Own store keeps the reservation; tag mismatch fails
        drive(1'b1, 1, 1'b1, 1'b0, 1'b0, 32'h200); step();
        drive(1'b1, 1, 1'b0, 1'b0, 1'b1, 32'h200); step();
        check("own_store_keeps", 32'(o_res_valid), 32'h0002);
        drive(1'b1, 1, 1'b0, 1'b1, 1'b0, 32'h200);
        check("sc1b_mem_we", 32'(o_sc_mem_we), 32'h1);
        step();
        check("sc1b_fail", 32'(o_sc_fail), 32'h0);
        drive(1'b1, 5, 1'b1, 1'b0, 1'b0, 32'h300); step();
        drive(1'b1, 5, 1'b0, 1'b1, 1'b0, 32'h304);
        check("sc5_mem_we", 32'(o_sc_mem_we), 32'h0);
        step();
        check("sc5_fail", 32'(o_sc_fail), 32'h1);

        // TIMEOUT=8: SC in cycle t+8 succeeds
        drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h40); step();
        idle(7);
        check("t8_still_valid", 32'(o_res_valid8[0]), 32'h1);
        drive(1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h40);
        check("t8_mem_we", 32'(o_sc_mem_we8), 32'h1);
        step();
        check("t8_fail", 32'(o_sc_fail8), 32'h0);
        // SC in cycle t+9 fails, reservation already gone
        drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h40); step();
        idle(8);
        check("t9_expired", 32'(o_res_valid8[0]), 32'h0);
        drive(1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h40);
        check("t9_mem_we", 32'(o_sc_mem_we8), 32'h0);
        step();
        check("t9_fail", 32'(o_sc_fail8), 32'h1);

        // All harts reserve one word; a successful SC clears everyone
        for (int h = 0; h < 16; h++) begin
            drive(1'b1, h, 1'b1, 1'b0, 1'b0, 32'h400); step();
        end
        check("all_reserved", 32'(o_res_valid), 32'hFFFF);
        drive(1'b1, 7, 1'b0, 1'b1, 1'b0, 32'h400);
        check("sc7_mem_we", 32'(o_sc_mem_we), 32'h1);
        step();
        check("sc7_clears_all", 32'(o_res_valid), 32'h0);
        drive(1'b1, 7, 1'b1, 1'b0, 1'b0, 32'h400); step();
        drive(1'b0, 7, 1'b0, 1'b1, 1'b0, 32'h400);
        check("bubble_mem_we", 32'(o_sc_mem_we), 32'h0);
        step();
        check("bubble_no_done", 32'(o_sc_done), 32'h0);
        check("bubble_no_change", 32'(o_res_valid), 32'h0080);

        // Asynchronous reset drops reservations and a pending SC result
        drive(1'b1, 2, 1'b1, 1'b0, 1'b0, 32'h500); step();
        check("lr2_valid", 32'(o_res_valid[2]), 32'h1);
        drive(1'b1, 9, 1'b0, 1'b1, 1'b0, 32'h700); step();
        check("pending_done", 32'(o_sc_done), 32'h1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(o_res_valid), 32'h0);
        check("async_rst_done",  32'(o_sc_done),   32'h0);
        step();
        reset = 1'b0;
        drive(1'b1, 2, 1'b0, 1'b1, 1'b0, 32'h500);
        check("post_rst_mem_we", 32'(o_sc_mem_we), 32'h0);
        step();
        check("post_rst_fail", 32'(o_sc_fail), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
